// File: rtl/gty_tx_prbs_gen.sv
// gty_tx_prbs_gen: PRBS7/9/15/23/31 word generator for a GTY TX datapath.
// When no pattern is selected, user data passes through with one cycle of
// latency. When a pattern is selected, the generator seeds itself, then emits
// one PRBS word per tx_ready strobe. Single bit-0 error injection is supported
// and counted in a saturating counter.
module gty_tx_prbs_gen #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  gty_txusrclk2,
  input  logic                  gty_tx_reset_reg,
  input  logic [3:0]            prbs_sel,
  input  logic                  prbs_force_err,
  input  logic [DATA_WIDTH-1:0] tx_data_in,
  input  logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  prbs_active,
  output logic [15:0]           err_inject_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEED = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  localparam logic [30:0] LFSR_SEED = {31{1'b1}};

  state_t                r_state;
  state_t                w_state_next;
  logic [30:0]           r_lfsr;
  logic [3:0]            r_sel;
  logic                  r_err_pending;
  logic                  w_err_pending_next;
  logic [15:0]           r_err_cnt;
  logic [DATA_WIDTH-1:0] r_tx_data;

  logic                  w_sel_valid;
  logic                  w_inject;
  logic [30:0]           w_lfsr_walk;
  logic [30:0]           w_lfsr_adv;
  logic [DATA_WIDTH-1:0] w_prbs_word;

  // The LFSR holds the next p sequence bits in its low p bits, oldest in
  // bit 0. One step emits bit 0 and shifts in b[n+p] = b[n] ^ b[n+p-q] at
  // bit p-1. Bits above p-1 are don't-care for the shorter polynomials.
  function automatic logic [30:0] lfsr_step(input logic [30:0] s,
                                            input logic [3:0]  sel);
    logic [30:0] n;
    n = s >> 1;
    case (sel)
      4'd1:    n[6]  = s[0] ^ s[1];   // PRBS7  (7,6)
      4'd2:    n[8]  = s[0] ^ s[4];   // PRBS9  (9,5)
      4'd3:    n[14] = s[0] ^ s[1];   // PRBS15 (15,14)
      4'd4:    n[22] = s[0] ^ s[5];   // PRBS23 (23,18)
      4'd5:    n[30] = s[0] ^ s[3];   // PRBS31 (31,28)
      default: n     = s;
    endcase
    return n;
  endfunction

  assign w_sel_valid = (prbs_sel >= 4'd1) && (prbs_sel <= 4'd5);

  // Unroll DATA_WIDTH serial steps: word bit i is the bit emitted at step i.
  always_comb begin
    w_lfsr_walk = r_lfsr;
    w_prbs_word = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      w_prbs_word[i] = w_lfsr_walk[0];
      w_lfsr_walk    = lfsr_step(w_lfsr_walk, r_sel);
    end
    w_lfsr_adv = w_lfsr_walk;
  end

  // Next-state, error-pending and injection decisions.
  always_comb begin
    w_state_next       = r_state;
    w_err_pending_next = r_err_pending;
    w_inject           = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Requests arriving in IDLE are dropped.
        w_err_pending_next = 1'b0;
        if (w_sel_valid) begin
          w_state_next = ST_SEED;
        end
      end
      ST_SEED: begin
        w_state_next       = ST_RUN;
        w_err_pending_next = r_err_pending | prbs_force_err;
      end
      ST_RUN: begin
        w_inject = tx_ready & r_err_pending;
        if (!w_sel_valid) begin
          w_state_next = ST_IDLE;
        end else if (prbs_sel != r_sel) begin
          w_state_next = ST_SEED;
        end
        if (!w_sel_valid) begin
          w_err_pending_next = 1'b0;
        end else if (w_inject) begin
          // A request coinciding with the injection re-arms for the next word.
          w_err_pending_next = prbs_force_err;
        end else begin
          w_err_pending_next = r_err_pending | prbs_force_err;
        end
      end
      default: begin
        w_state_next       = ST_IDLE;
        w_err_pending_next = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge gty_txusrclk2 or posedge gty_tx_reset_reg) begin
    if (gty_tx_reset_reg) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Output word, LFSR and latched select, updated per state.
  always_ff @(posedge gty_txusrclk2 or posedge gty_tx_reset_reg) begin
    if (gty_tx_reset_reg) begin
      r_tx_data <= '0;
      r_lfsr    <= LFSR_SEED;
      r_sel     <= 4'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_tx_data <= tx_data_in;
        end
        ST_SEED: begin
          r_tx_data <= '0;
          r_lfsr    <= LFSR_SEED;
          r_sel     <= prbs_sel;
        end
        ST_RUN: begin
          if (tx_ready) begin
            // Inversion is applied to the output only; the LFSR is untouched.
            r_tx_data <= w_prbs_word ^ {{(DATA_WIDTH-1){1'b0}}, w_inject};
            r_lfsr    <= w_lfsr_adv;
          end
        end
        default: begin
          r_tx_data <= '0;
        end
      endcase
    end
  end

  // Pending-error flag and saturating injection counter.
  always_ff @(posedge gty_txusrclk2 or posedge gty_tx_reset_reg) begin
    if (gty_tx_reset_reg) begin
      r_err_pending <= 1'b0;
      r_err_cnt     <= 16'd0;
    end else begin
      r_err_pending <= w_err_pending_next;
      if (w_inject && (r_err_cnt != 16'hFFFF)) begin
        r_err_cnt <= r_err_cnt + 16'd1;
      end
    end
  end

  assign tx_data          = r_tx_data;
  assign prbs_active      = (r_state == ST_RUN);
  assign err_inject_count = r_err_cnt;

endmodule
